pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised data-hazard and operand-forwarding controller for the in-order core pipeline.
- Tracks destination registers of in-flight instructions from EX through WB in a shift-register scoreboard.
- Covers both integer and FP register classes, and any number of source operands (NUM_SRC=3 covers fmadd).
- Drives the load-use stall, applies flush on branch redirect, and muxes forwarded operands into the decode→exec handoff.

Parameters:
- XLEN, 32: operand/result width.
- RA_W, 5: register address width.
- NUM_SRC, 2: source operands per instruction.
- FWD_DEPTH, 3: tracked stages after decode; index 0=EX out, 1=MEM out, 2=WB in.
- LOAD_AVAIL, 1: first stage index at which a load result is valid.
- SEL_W, $clog2(FWD_DEPTH+1): forwarding select width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous reset, active-low
- advance  in  1  pipeline step this cycle (all stages completed)
- flush  in  1  redirect taken; kill instruction currently in decode
- id_valid  in  1  decode holds a valid instruction
- id_rs  in  NUM_SRC*RA_W  source addresses
- id_rs_used  in  NUM_SRC  source actually read
- id_rs_fp  in  NUM_SRC  source class (1=FP)
- id_rd  in  RA_W  destination
- id_rd_fp  in  1  destination class
- id_writes  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- id_rf_data  in  NUM_SRC*XLEN  register-file read values
- stage_data  in  FWD_DEPTH*XLEN  result per tracked stage
- stall  out  1  hold fetch/decode, inject bubble into EX
- fwd_sel  out  NUM_SRC*SEL_W  0=regfile, k=stage k-1
- op_data  out  NUM_SRC*XLEN  muxed operands
- stall_cnt  out  32  stall cycles since reset
- flush_cnt  out  32  flushes since reset

Behaviour:
- Entry k holds: valid, rd, rd_fp, writes, is_load. Entries are registers; stall, fwd_sel and op_data are combinational from entries + id_* inputs.
- Match for source s:
  - Conditions: id_valid, id_rs_used[s], entry valid and writes, rd==rs, rd_fp==rs_fp.
  - An integer source with rs==0 never matches; FP register 0 is a normal register.
- Lowest matching index k (youngest) wins. No match → fwd_sel=0, op_data=id_rf_data.
- Youngest match that is a load with k<LOAD_AVAIL → hazard; fwd_sel forced 0.
- Otherwise fwd_sel=k+1, op_data=stage_data[k]. Older matches are ignored.
- stall = any source hazard && !flush.
- On advance (update order):
  - Entries k≥1 take entry k-1.
  - Entry 0 takes the decode instruction iff id_valid && !stall && !flush; otherwise a bubble (valid=0).
- No advance → entries hold and counters hold.
- Stall duration: a load followed directly by a dependent instruction stalls LOAD_AVAIL advances, then forwards from stage index LOAD_AVAIL. Non-load producers never stall.
- flush && stall in the same cycle: flush wins, stall=0, flush_cnt increments.
- stall_cnt increments on each advance with stall=1. flush_cnt increments on each advance with flush=1. Both wrap at 2^32.
- Reset (rstn=0 at clk edge):
  - All entries invalid; stall_cnt=0, flush_cnt=0.
  - Outputs then follow combinationally: stall=0, fwd_sel=0, op_data=id_rf_data.
  - Reset mid-stall discards the stall with no further bubble.
- stage_data[k] is only consumed when entry k is valid. WB-stage forwarding covers same-cycle regfile write, so the regfile needs no write-first behaviour.

Test Plan:
- Default params. `add x5,x1,x2` then `sub x6,x5,x3` on consecutive advances, stage_data[0]=0x11 → stall=0, fwd_sel[0]=1, op_data[0]=0x11.
- `lw x7` then `add x8,x7,x7` → one advance with stall=1 and stall_cnt=1. Next cycle fwd_sel=2 for both sources, op_data=stage_data[1]=0xDEADBEEF.
- Write x9 at entries 0 and 2 simultaneously with stage_data=0xA/0xB/0xC → youngest wins, op_data=0xA.
- Integer source x0 with an entry writing x0 → fwd_sel=0. `fmul f0` followed by `fadd` reading f0 → fwd_sel=1.
- Load-use hazard with flush=1 in the same cycle → stall=0, entry 0 bubble, flush_cnt=1. Following instruction fetched without hazard.
- NUM_SRC=3, FWD_DEPTH=4, LOAD_AVAIL=2: dependent fmadd directly after `flw f3` (rs3=f3) → stalls two advances, then fwd_sel[2]=3. Assert rstn=0 mid-stall → stall drops and counters read 0 the next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Data-hazard / operand-forwarding controller for the in-order core pipeline.
// Shift-register scoreboard of in-flight destinations (EX..WB); picks the
// youngest producer per source operand, raises load-use stall, muxes operands.
module pipe_hazard_ctrl #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned RA_W       = 5,
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned FWD_DEPTH  = 3,
   parameter int unsigned LOAD_AVAIL = 1,
   parameter int unsigned SEL_W      = $clog2(FWD_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       advance,
   input  logic                       flush,
   input  logic                       id_valid,
   input  logic [NUM_SRC*RA_W-1:0]    id_rs,
   input  logic [NUM_SRC-1:0]         id_rs_used,
   input  logic [NUM_SRC-1:0]         id_rs_fp,
   input  logic [RA_W-1:0]            id_rd,
   input  logic                       id_rd_fp,
   input  logic                       id_writes,
   input  logic                       id_is_load,
   input  logic [NUM_SRC*XLEN-1:0]    id_rf_data,
   input  logic [FWD_DEPTH*XLEN-1:0]  stage_data,
   output logic                       stall,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
   output logic [NUM_SRC*XLEN-1:0]    op_data,
   output logic [31:0]                stall_cnt,
   output logic [31:0]                flush_cnt
);

   logic              r_valid   [FWD_DEPTH];
   logic [RA_W-1:0]   r_rd      [FWD_DEPTH];
   logic              r_rd_fp   [FWD_DEPTH];
   logic              r_writes  [FWD_DEPTH];
   logic              r_is_load [FWD_DEPTH];
   logic [31:0]       r_stall_cnt;
   logic [31:0]       r_flush_cnt;
   logic              w_hazard;

   // Per source: find youngest matching producer, then forward it or flag a load-use hazard
   always_comb begin : p_fwd
      logic              w_hit;
      logic              w_early;
      logic [SEL_W-1:0]  w_sel;
      logic [XLEN-1:0]   w_data;
      logic [RA_W-1:0]   w_rs;
      w_hazard = 1'b0;
      fwd_sel  = '0;
      op_data  = id_rf_data;
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         w_hit   = 1'b0;
         w_early = 1'b0;
         w_sel   = '0;
         w_data  = '0;
         w_rs    = id_rs[s*RA_W +: RA_W];
         for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
            if (!w_hit && id_valid && id_rs_used[s] && r_valid[k] && r_writes[k] &&
                (r_rd[k] == w_rs) && (r_rd_fp[k] == id_rs_fp[s]) &&
                (id_rs_fp[s] || (w_rs != '0))) begin
               w_hit   = 1'b1;
               w_early = r_is_load[k] && (k < LOAD_AVAIL);
               w_sel   = SEL_W'(k + 1);
               w_data  = stage_data[k*XLEN +: XLEN];
            end
         end
         if (w_hit) begin
            if (w_early) begin
               w_hazard = 1'b1;
            end else begin
               fwd_sel[s*SEL_W +: SEL_W] = w_sel;
               op_data[s*XLEN +: XLEN]   = w_data;
            end
         end
      end
   end

   assign stall     = w_hazard & ~flush;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

   // Scoreboard shift on advance; decode enters entry 0 unless stalled or flushed
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
            r_valid[k]   <= 1'b0;
            r_rd[k]      <= '0;
            r_rd_fp[k]   <= 1'b0;
            r_writes[k]  <= 1'b0;
            r_is_load[k] <= 1'b0;
         end
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (advance) begin
         for (int unsigned k = 1; k < FWD_DEPTH; k++) begin
            r_valid[k]   <= r_valid[k-1];
            r_rd[k]      <= r_rd[k-1];
            r_rd_fp[k]   <= r_rd_fp[k-1];
            r_writes[k]  <= r_writes[k-1];
            r_is_load[k] <= r_is_load[k-1];
         end
         r_valid[0]   <= id_valid & ~stall & ~flush;
         r_rd[0]      <= id_rd;
         r_rd_fp[0]   <= id_rd_fp;
         r_writes[0]  <= id_writes;
         r_is_load[0] <= id_is_load;
         if (stall) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (flush) r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one stimulus stream drives a default instance (A)
// and a 3-source / 4-deep / load-latency-2 instance (B), both checked against
// an age-ordered in-flight instruction model.
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // shared stimulus
   logic        t_rstn, t_adv, t_flush, t_valid, t_rdfp, t_wr, t_ld;
   logic [4:0]  t_rd;
   logic [4:0]  t_rs [3];
   logic [2:0]  t_used, t_rsfp;
   logic [31:0] t_rf [3];
   logic [31:0] t_sd [4];

   logic [9:0]   a_rs;
   logic [63:0]  a_rf;
   logic [95:0]  a_sd;
   logic         a_stall;
   logic [3:0]   a_sel;
   logic [63:0]  a_op;
   logic [31:0]  a_scnt, a_fcnt;
   logic [14:0]  b_rs;
   logic [95:0]  b_rf;
   logic [127:0] b_sd;
   logic         b_stall;
   logic [8:0]   b_sel;
   logic [95:0]  b_op;
   logic [31:0]  b_scnt, b_fcnt;

   assign a_rs = {t_rs[1], t_rs[0]};
   assign a_rf = {t_rf[1], t_rf[0]};
   assign a_sd = {t_sd[2], t_sd[1], t_sd[0]};
   assign b_rs = {t_rs[2], t_rs[1], t_rs[0]};
   assign b_rf = {t_rf[2], t_rf[1], t_rf[0]};
   assign b_sd = {t_sd[3], t_sd[2], t_sd[1], t_sd[0]};

   pipe_hazard_ctrl u_a (
      .clk(clk), .rstn(t_rstn), .advance(t_adv), .flush(t_flush), .id_valid(t_valid),
      .id_rs(a_rs), .id_rs_used(t_used[1:0]), .id_rs_fp(t_rsfp[1:0]), .id_rd(t_rd),
      .id_rd_fp(t_rdfp), .id_writes(t_wr), .id_is_load(t_ld), .id_rf_data(a_rf),
      .stage_data(a_sd), .stall(a_stall), .fwd_sel(a_sel), .op_data(a_op),
      .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
   );

   pipe_hazard_ctrl #(.NUM_SRC(3), .FWD_DEPTH(4), .LOAD_AVAIL(2)) u_b (
      .clk(clk), .rstn(t_rstn), .advance(t_adv), .flush(t_flush), .id_valid(t_valid),
      .id_rs(b_rs), .id_rs_used(t_used), .id_rs_fp(t_rsfp), .id_rd(t_rd),
      .id_rd_fp(t_rdfp), .id_writes(t_wr), .id_is_load(t_ld), .id_rf_data(b_rf),
      .stage_data(b_sd), .stall(b_stall), .fwd_sel(b_sel), .op_data(b_op),
      .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
   );

   // model: per instance, in-flight instructions indexed by age (0 = youngest)
   int          D  [2] = '{3, 4};
   int          LA [2] = '{1, 2};
   int          NS [2] = '{2, 3};
   logic        m_v  [2][4];
   logic        m_fp [2][4];
   logic        m_wr [2][4];
   logic        m_ld [2][4];
   logic [4:0]  m_rd [2][4];
   logic [31:0] m_sc [2];
   logic [31:0] m_fc [2];
   logic        e_stall [2];
   int          e_sel [2][3];
   logic [31:0] e_op  [2][3];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic compute(input int i);
      logic hz;
      logic found;
      hz = 1'b0;
      for (int s = 0; s < 3; s++) begin
         e_sel[i][s] = 0;
         e_op[i][s]  = t_rf[s];
         if (s < NS[i] && t_valid && t_used[s] && (t_rsfp[s] || t_rs[s] != 5'd0)) begin
            found = 1'b0;
            for (int a = 0; a < D[i]; a++) begin
               if (!found && m_v[i][a] && m_wr[i][a] && m_rd[i][a] == t_rs[s] &&
                   m_fp[i][a] == t_rsfp[s]) begin
                  found = 1'b1;
                  if (m_ld[i][a] && a < LA[i]) hz = 1'b1;
                  else begin
                     e_sel[i][s] = a + 1;
                     e_op[i][s]  = t_sd[a];
                  end
               end
            end
         end
      end
      e_stall[i] = hz && !t_flush;
   endtask

   task automatic update(input int i);
      if (!t_rstn) begin
         for (int a = 0; a < 4; a++) m_v[i][a] = 1'b0;
         m_sc[i] = 32'd0;
         m_fc[i] = 32'd0;
      end else if (t_adv) begin
         for (int a = D[i] - 1; a >= 1; a--) begin
            m_v[i][a]  = m_v[i][a-1];
            m_fp[i][a] = m_fp[i][a-1];
            m_wr[i][a] = m_wr[i][a-1];
            m_ld[i][a] = m_ld[i][a-1];
            m_rd[i][a] = m_rd[i][a-1];
         end
         m_v[i][0]  = t_valid && !e_stall[i] && !t_flush;
         m_fp[i][0] = t_rdfp;
         m_wr[i][0] = t_wr;
         m_ld[i][0] = t_ld;
         m_rd[i][0] = t_rd;
         if (e_stall[i]) m_sc[i] = m_sc[i] + 32'd1;
         if (t_flush)    m_fc[i] = m_fc[i] + 32'd1;
      end
   endtask

   task automatic eval();
      #1;
      compute(0);
      compute(1);
      chk("A.stall", {31'b0, a_stall}, {31'b0, e_stall[0]});
      chk("A.stall_cnt", a_scnt, m_sc[0]);
      chk("A.flush_cnt", a_fcnt, m_fc[0]);
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("A.fwd_sel%0d", s), 32'(a_sel[s*2 +: 2]), 32'(e_sel[0][s]));
         chk($sformatf("A.op_data%0d", s), a_op[s*32 +: 32], e_op[0][s]);
      end
      chk("B.stall", {31'b0, b_stall}, {31'b0, e_stall[1]});
      chk("B.stall_cnt", b_scnt, m_sc[1]);
      chk("B.flush_cnt", b_fcnt, m_fc[1]);
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("B.fwd_sel%0d", s), 32'(b_sel[s*3 +: 3]), 32'(e_sel[1][s]));
         chk($sformatf("B.op_data%0d", s), b_op[s*32 +: 32], e_op[1][s]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      update(0);
      update(1);
      #1;
   endtask

   task automatic instr(input logic v, input logic [4:0] rd, input logic rdfp, input logic wr,
                        input logic ld, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [2:0] used, input logic [2:0] fp);
      t_valid = v;  t_rd = rd;  t_rdfp = rdfp;  t_wr = wr;  t_ld = ld;
      t_rs[0] = r0; t_rs[1] = r1; t_rs[2] = r2;
      t_used = used; t_rsfp = fp;
   endtask

   initial begin
      t_rstn = 1'b0; t_adv = 1'b1; t_flush = 1'b0;
      instr(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
      t_rf[0] = 32'h100; t_rf[1] = 32'h200; t_rf[2] = 32'h300;
      for (int k = 0; k < 4; k++) t_sd[k] = 32'h1000 + 32'(k);

      // reset state
      tick();
      eval();
      chk("rst.op0", a_op[31:0], 32'h100);
      chk("rst.stall_cnt", a_scnt, 32'd0);
      tick();
      t_rstn = 1'b1;

      // ALU forward: add x5,x1,x2 ; sub x6,x5,x3
      instr(1, 5, 0, 1, 0, 1, 2, 0, 3'b011, 3'b000); eval(); tick();
      instr(1, 6, 0, 1, 0, 5, 3, 0, 3'b011, 3'b000); t_sd[0] = 32'h11; eval();
      chk("alu.stall", {31'b0, a_stall}, 32'd0);
      chk("alu.sel0", 32'(a_sel[1:0]), 32'd1);
      chk("alu.op0", a_op[31:0], 32'h11);
      tick();

      // load-use: lw x7 ; add x8,x7,x7
      instr(1, 7, 0, 1, 1, 1, 0, 0, 3'b001, 3'b000); eval(); tick();
      instr(1, 8, 0, 1, 0, 7, 7, 0, 3'b011, 3'b000); t_sd[1] = 32'hDEADBEEF; eval();
      chk("ld.stall", {31'b0, a_stall}, 32'd1);
      tick(); eval();
      chk("ld.stall_cnt", a_scnt, 32'd1);
      chk("ld.after_stall", {31'b0, a_stall}, 32'd0);
      chk("ld.sel0", 32'(a_sel[1:0]), 32'd2);
      chk("ld.sel1", 32'(a_sel[3:2]), 32'd2);
      chk("ld.op1", a_op[63:32], 32'hDEADBEEF);
      tick();

      // youngest wins: x9 at entries 0 and 2
      instr(1, 9, 0, 1, 0, 0, 0, 0, 3'b000, 3'b000); eval(); tick();
      instr(1, 10, 0, 1, 0, 0, 0, 0, 3'b000, 3'b000); eval(); tick();
      instr(1, 9, 0, 1, 0, 0, 0, 0, 3'b000, 3'b000); eval(); tick();
      instr(1, 11, 0, 1, 0, 9, 0, 0, 3'b001, 3'b000);
      t_sd[0] = 32'hA; t_sd[1] = 32'hB; t_sd[2] = 32'hC; eval();
      chk("young.sel0", 32'(a_sel[1:0]), 32'd1);
      chk("young.op0", a_op[31:0], 32'hA);
      chk("young.B.op0", b_op[31:0], 32'hA);
      tick();

      // x0 never forwarded, f0 is
      instr(1, 0, 0, 1, 0, 0, 0, 0, 3'b000, 3'b000); eval(); tick();
      instr(1, 12, 0, 1, 0, 0, 0, 0, 3'b001, 3'b000); eval();
      chk("x0.sel0", 32'(a_sel[1:0]), 32'd0);
      chk("x0.op0", a_op[31:0], 32'h100);
      tick();
      instr(1, 0, 1, 1, 0, 1, 2, 0, 3'b011, 3'b011); eval(); tick();
      instr(1, 1, 1, 1, 0, 0, 0, 0, 3'b011, 3'b001); eval();
      chk("f0.sel0", 32'(a_sel[1:0]), 32'd1);
      chk("f0.sel1_x0", 32'(a_sel[3:2]), 32'd0);
      tick();

      // load-use coinciding with flush
      instr(1, 7, 0, 1, 1, 0, 0, 0, 3'b000, 3'b000); eval(); tick();
      instr(1, 13, 0, 1, 0, 7, 0, 0, 3'b001, 3'b000); t_flush = 1'b1; eval();
      chk("flush.stall", {31'b0, a_stall}, 32'd0);
      tick();
      t_flush = 1'b0; eval();
      chk("flush.cnt", a_fcnt, 32'd1);
      chk("flush.next_stall", {31'b0, a_stall}, 32'd0);
      tick();

      // instance B: flw f3 ; fmadd f4,f1,f2,f3 stalls two advances
      instr(1, 3, 1, 1, 1, 0, 0, 0, 3'b000, 3'b000); eval(); tick();
      instr(1, 4, 1, 1, 0, 1, 2, 3, 3'b111, 3'b111); eval();
      chk("fma.stall1", {31'b0, b_stall}, 32'd1);
      tick(); eval();
      chk("fma.stall2", {31'b0, b_stall}, 32'd1);
      tick(); eval();
      chk("fma.go", {31'b0, b_stall}, 32'd0);
      chk("fma.sel2", 32'(b_sel[8:6]), 32'd3);
      tick();

      // reset in the middle of a load-use stall
      instr(1, 3, 1, 1, 1, 0, 0, 0, 3'b000, 3'b000); eval(); tick();
      instr(1, 4, 1, 1, 0, 1, 2, 3, 3'b111, 3'b111); eval();
      chk("rstmid.stall", {31'b0, b_stall}, 32'd1);
      t_rstn = 1'b0;
      tick();
      t_rstn = 1'b1; eval();
      chk("rstmid.B.stall", {31'b0, b_stall}, 32'd0);
      chk("rstmid.B.stall_cnt", b_scnt, 32'd0);
      chk("rstmid.B.flush_cnt", b_fcnt, 32'd0);
      chk("rstmid.A.stall_cnt", a_scnt, 32'd0);
      tick();

      // randomized traffic on a small register window to provoke hazards
      repeat (600) begin
         t_rstn  = ($urandom_range(0, 99) != 0);
         t_adv   = ($urandom_range(0, 9) < 8);
         t_flush = ($urandom_range(0, 9) == 0);
         t_valid = ($urandom_range(0, 9) != 0);
         t_rd    = 5'($urandom_range(0, 3));
         t_rdfp  = 1'($urandom_range(0, 1));
         t_wr    = ($urandom_range(0, 4) != 0);
         t_ld    = ($urandom_range(0, 2) == 0);
         t_used  = 3'($urandom);
         t_rsfp  = 3'($urandom);
         for (int s = 0; s < 3; s++) begin
            t_rs[s] = 5'($urandom_range(0, 3));
            t_rf[s] = $urandom;
         end
         for (int k = 0; k < 4; k++) t_sd[k] = $urandom;
         eval();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
